oam_dma_ctrl: RTL

- Sprite DMA controller for the CPU memory map.
- A CPU write to the DMA register (0x4014) starts a transfer. The block halts the CPU, takes the CPU memory bus, and copies 256 bytes from page {data,8'h00} into PPU SPRAM starting at the current OAM address.
- It sits between the CPU core, the CPU main-memory read port and the CPU-side SPRAM write port.
- All sequencing is paced by the CPU cycle strobe, so a transfer lasts 513 or 514 CPU cycles.

---
 rtl/nes_mem_pkg.sv | 24 ++
 rtl/oam_dma_ctrl_if.sv | 40 ++++
 rtl/oam_dma_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/nes_mem_pkg.sv
// ============================================================================
// Module   : nes_mem_pkg
// Brief    : Shared CPU memory-map constants and the sprite-DMA state type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nes_mem_pkg;

  localparam logic [15:0] C_DMA_REG_ADDR  = 16'h4014;
  // OAM data port; decoded by the top-level bus mux, not by the DMA block.
  localparam logic [15:0] C_OAM_DATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_t;

endpackage

`default_nettype wire

// File: rtl/oam_dma_ctrl_if.sv
// ============================================================================
// Module   : oam_dma_ctrl_if
// Brief    : CPU-bus, memory-read and SPRAM-write signals of the sprite DMA.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface oam_dma_ctrl_if;

  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_stall;
  logic        dma_busy;
  logic [15:0] dma_mem_addr;
  logic        dma_mem_re;
  logic [7:0]  mem_rdata;
  logic [7:0]  oam_base;
  logic [7:0]  spram_addr;
  logic [7:0]  spram_data;
  logic        spram_we;

  // DMA controller side
  modport master (
    input  cpu_ce, cpu_addr, cpu_wdata, cpu_we, mem_rdata, oam_base,
    output cpu_stall, dma_busy, dma_mem_addr, dma_mem_re,
           spram_addr, spram_data, spram_we
  );

  // System side: CPU core, memory port and SPRAM
  modport slave (
    output cpu_ce, cpu_addr, cpu_wdata, cpu_we, mem_rdata, oam_base,
    input  cpu_stall, dma_busy, dma_mem_addr, dma_mem_re,
           spram_addr, spram_data, spram_we
  );

endinterface

`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
// ============================================================================
// Module   : oam_dma_ctrl
// Brief    : Sprite DMA: copies one CPU page into SPRAM while stalling the CPU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module oam_dma_ctrl
  import nes_mem_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = C_DMA_REG_ADDR,
  parameter int          XFER_LEN     = 256   // power of two, at most 256
) (
  input  logic clk,
  input  logic rst,
  oam_dma_ctrl_if.master bus
);

  localparam logic [7:0] C_LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t  r_state,      w_state_nxt;
  logic        r_cyc_odd;
  logic [7:0]  r_page,       w_page_nxt;
  logic [7:0]  r_base,       w_base_nxt;
  logic [7:0]  r_idx,        w_idx_nxt;
  logic [7:0]  r_data,       w_data_nxt;
  logic        r_stall,      w_stall_nxt;
  logic        r_busy,       w_busy_nxt;
  logic [15:0] r_mem_addr,   w_mem_addr_nxt;
  logic        r_mem_re,     w_mem_re_nxt;
  logic [7:0]  r_spram_addr, w_spram_addr_nxt;
  logic [7:0]  r_spram_data, w_spram_data_nxt;
  logic        r_spram_we,   w_spram_we_nxt;
  logic        w_trigger;

  assign w_trigger = bus.cpu_ce & bus.cpu_we & (bus.cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cyc_odd    <= 1'b0;
      r_page       <= 8'h00;
      r_base       <= 8'h00;
      r_idx        <= 8'h00;
      r_data       <= 8'h00;
      r_stall      <= 1'b0;
      r_busy       <= 1'b0;
      r_mem_addr   <= 16'h0000;
      r_mem_re     <= 1'b0;
      r_spram_addr <= 8'h00;
      r_spram_data <= 8'h00;
      r_spram_we   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cyc_odd    <= r_cyc_odd ^ bus.cpu_ce;
      r_page       <= w_page_nxt;
      r_base       <= w_base_nxt;
      r_idx        <= w_idx_nxt;
      r_data       <= w_data_nxt;
      r_stall      <= w_stall_nxt;
      r_busy       <= w_busy_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_re     <= w_mem_re_nxt;
      r_spram_addr <= w_spram_addr_nxt;
      r_spram_data <= w_spram_data_nxt;
      r_spram_we   <= w_spram_we_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_page_nxt       = r_page;
    w_base_nxt       = r_base;
    w_idx_nxt        = r_idx;
    w_data_nxt       = r_data;
    w_stall_nxt      = r_stall;
    w_busy_nxt       = r_busy;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_re_nxt     = r_mem_re;
    w_spram_addr_nxt = r_spram_addr;
    w_spram_data_nxt = r_spram_data;
    w_spram_we_nxt   = 1'b0;

    if (bus.cpu_ce) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            w_page_nxt  = bus.cpu_wdata;
            w_base_nxt  = bus.oam_base;
            w_idx_nxt   = 8'h00;
            w_stall_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
            w_state_nxt = ST_HALT;
          end
        end
        ST_HALT: begin
          if (r_cyc_odd) begin
            w_state_nxt = ST_ALIGN;
          end else begin
            w_mem_addr_nxt = {r_page, r_idx};
            w_mem_re_nxt   = 1'b1;
            w_state_nxt    = ST_READ;
          end
        end
        ST_ALIGN: begin
          w_mem_addr_nxt = {r_page, r_idx};
          w_mem_re_nxt   = 1'b1;
          w_state_nxt    = ST_READ;
        end
        ST_READ: begin
          w_data_nxt   = bus.mem_rdata;
          w_mem_re_nxt = 1'b0;
          w_state_nxt  = ST_WRITE;
        end
        ST_WRITE: begin
          w_spram_we_nxt   = 1'b1;
          w_spram_addr_nxt = r_base + r_idx;
          w_spram_data_nxt = r_data;
          if (r_idx == C_LAST_IDX) begin
            // Bus is released on the same edge as the final SPRAM strobe.
            w_stall_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_idx_nxt      = r_idx + 8'd1;
            w_mem_addr_nxt = {r_page, r_idx + 8'd1};
            w_mem_re_nxt   = 1'b1;
            w_state_nxt    = ST_READ;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_stall    = r_stall;
  assign bus.dma_busy     = r_busy;
  assign bus.dma_mem_addr = r_mem_addr;
  assign bus.dma_mem_re   = r_mem_re;
  assign bus.spram_addr   = r_spram_addr;
  assign bus.spram_data   = r_spram_data;
  assign bus.spram_we     = r_spram_we;

endmodule

`default_nettype wire
